// File: rtl/per2axi_res_buffer.sv
// per2axi response path: merges AXI R/B beats through a round-robin arbiter
// into a small FIFO returned to the peripheral interconnect.
module per2axi_res_buffer #(
   parameter int PER_ID_WIDTH   = 5,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_USER_WIDTH = 6,
   parameter int AXI_ID_WIDTH   = 3,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   output logic                      per_slave_r_valid_o,
   input  logic                      per_slave_r_ready_i,
   output logic                      per_slave_r_opc_o,
   output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
   output logic [31:0]               per_slave_r_rdata_o,
   input  logic                      axi_master_r_valid_i,
   input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
   input  logic [1:0]                axi_master_r_resp_i,
   input  logic                      axi_master_r_last_i,
   input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
   input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
   output logic                      axi_master_r_ready_o,
   input  logic                      axi_master_b_valid_i,
   input  logic [1:0]                axi_master_b_resp_i,
   input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
   input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
   output logic                      axi_master_b_ready_o,
   input  logic                      trans_req_i,
   input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
   input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
   output logic [7:0]                err_cnt_o
);

   localparam int NLANES = AXI_DATA_WIDTH / 32;
   localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   typedef struct packed {
      logic                    opc;
      logic [PER_ID_WIDTH-1:0] id;
      logic [31:0]             rdata;
   } entry_t;

   typedef enum logic {PRIO_R = 1'b0, PRIO_B = 1'b1} prio_e;

   logic [LANE_W-1:0] r_lane_tbl [PER_ID_WIDTH];
   entry_t            r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_cnt;
   logic [7:0]        r_err_cnt;
   prio_e             r_prio;
   prio_e             w_prio_nxt;

   logic              w_full;
   logic              w_empty;
   logic              w_r_rdy;
   logic              w_b_rdy;
   logic              w_gnt_r;
   logic              w_gnt_b;
   logic              w_push;
   logic              w_pop;
   logic [LANE_W-1:0] w_lane;
   logic [31:0]       w_rdata;
   entry_t            w_entry;
   entry_t            w_head;
   logic              w_unused;

   assign w_unused = ^{axi_master_r_user_i, axi_master_b_user_i,
                       axi_master_r_last_i, trans_add_i};

   assign w_full  = (r_cnt == CNT_W'(FIFO_DEPTH));
   assign w_empty = (r_cnt == '0);

   // Readies depend only on registered state and AXI valids, never on the
   // peripheral ready, so a full FIFO stays closed even while it drains.
   assign w_r_rdy = !w_full && (r_prio == PRIO_R || !axi_master_b_valid_i);
   assign w_b_rdy = !w_full && (r_prio == PRIO_B || !axi_master_r_valid_i);
   assign w_gnt_r = w_r_rdy && axi_master_r_valid_i;
   assign w_gnt_b = w_b_rdy && axi_master_b_valid_i;
   assign w_push  = w_gnt_r || w_gnt_b;
   assign w_pop   = !w_empty && per_slave_r_ready_i;

   assign axi_master_r_ready_o = w_r_rdy;
   assign axi_master_b_ready_o = w_b_rdy;

   always_comb begin
      w_prio_nxt = r_prio;
      if (w_gnt_r) w_prio_nxt = PRIO_B;
      else if (w_gnt_b) w_prio_nxt = PRIO_R;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_prio <= PRIO_R;
      else         r_prio <= w_prio_nxt;
   end

   always_comb begin
      w_lane = '0;
      for (int i = 0; i < PER_ID_WIDTH; i++) begin
         if (NLANES > 1 && axi_master_r_id_i == AXI_ID_WIDTH'(i))
            w_lane = r_lane_tbl[i];
      end
   end

   always_comb begin
      w_rdata = axi_master_r_data_i[31:0];
      for (int j = 0; j < NLANES; j++) begin
         if (w_lane == LANE_W'(j))
            w_rdata = axi_master_r_data_i[32*j +: 32];
      end
   end

   always_comb begin
      w_entry = '0;
      if (w_gnt_r) begin
         w_entry.opc   = axi_master_r_resp_i[1];
         w_entry.id    = PER_ID_WIDTH'(1) << axi_master_r_id_i;
         w_entry.rdata = w_rdata;
      end else if (w_gnt_b) begin
         w_entry.opc   = axi_master_b_resp_i[1];
         w_entry.id    = PER_ID_WIDTH'(1) << axi_master_b_id_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < PER_ID_WIDTH; i++) r_lane_tbl[i] <= '0;
      end else if (trans_req_i) begin
         for (int i = 0; i < PER_ID_WIDTH; i++) begin
            if (trans_id_i == AXI_ID_WIDTH'(i))
               r_lane_tbl[i] <= (NLANES > 1) ? trans_add_i[2 +: LANE_W] : '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= w_entry;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop) r_cnt <= r_cnt + 1'b1;
         else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_err_cnt <= '0;
      else if (w_push && w_entry.opc && r_err_cnt != 8'hFF)
         r_err_cnt <= r_err_cnt + 1'b1;
   end

   assign w_head              = w_empty ? '0 : r_mem[r_rptr];
   assign per_slave_r_valid_o = !w_empty;
   assign per_slave_r_opc_o   = w_head.opc;
   assign per_slave_r_id_o    = w_head.id;
   assign per_slave_r_rdata_o = w_head.rdata;
   assign err_cnt_o           = r_err_cnt;

endmodule
